// File: rtl/booth3_seq_mult_ctrl.sv
// booth3_seq_mult_ctrl: sequential signed radix-8 Booth multiplier controller.
// The 3A multiple is formed once, then one Booth-3 digit is retired per cycle.
module booth3_seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int NDIG = (WIDTH + 3) / 3;
    localparam int YW   = 3 * NDIG + 1;
    localparam int CW   = $clog2(NDIG + 1);
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, PRE, DIG, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [YW-1:0]    y_q, y_d;
    logic [WIDTH+1:0] m3_q, m3_d;
    logic [PW-1:0]    acc_q, acc_d, prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       grp, dabs;
    logic signed [3:0] dig;
    logic [PW-1:0]    a_ext, m3_ext, pos, sel;

    // y_q holds the multiplier with y[-1] at bit 0 and is shifted 3 bits per digit
    always_comb begin
        grp    = y_q[3:0];
        dig    = $signed({grp[3], grp[3:1]}) + $signed({3'b000, grp[0]});
        dabs   = dig[3] ? -dig : dig;
        a_ext  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        m3_ext = {{(PW-WIDTH-2){m3_q[WIDTH+1]}}, m3_q};
        pos    = dabs == 4'd1 ? a_ext :
                 dabs == 4'd2 ? a_ext << 1 :
                 dabs == 4'd3 ? m3_ext :
                 dabs == 4'd4 ? a_ext << 2 : '0;
        sel    = dig[3] ? -pos : pos;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        y_d     = y_q;
        m3_d    = m3_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                y_d     = {{(YW-1-WIDTH){b[WIDTH-1]}}, b, 1'b0};
                acc_d   = '0;
                cnt_d   = '0;
                state_d = PRE;
            end
            PRE: begin
                m3_d    = {a_q[WIDTH-1], a_q[WIDTH-1], a_q} + {a_q[WIDTH-1], a_q, 1'b0};
                state_d = DIG;
            end
            DIG: if (cnt_q == CW'(NDIG)) begin
                prod_d  = acc_q;
                state_d = DONE;
            end else begin
                acc_d = acc_q + (sel << (3 * cnt_q));
                y_d   = y_q >> 3;
                cnt_d = cnt_q + 1'b1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            y_q     <= '0;
            m3_q    <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            y_q     <= y_d;
            m3_q    <= m3_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign product   = prod_q;
endmodule

// File: tb/tb_booth3_seq_mult_ctrl.sv
// tb_booth3_seq_mult_ctrl: directed and randomized checks of the Booth-3 multiplier controller.
module tb_booth3_seq_mult_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, in_ready, out_valid, busy;
    logic [7:0]  a, b;
    logic [15:0] product;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          lat;

    always #5 clk = ~clk;

    booth3_seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept happens at the posedge between the two negedges; a/b are scrambled afterwards
    task automatic start(input logic [7:0] av, input logic [7:0] bv);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("start_ready", in_ready, 1);
        a = av;
        b = bv;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp, input string tag);
        int l;
        out_ready = 1;
        start(av, bv);
        wait_done(l);
        check({tag, "_lat"}, l, 5);
        check(tag, product, exp);
        @(negedge clk);
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        logic [7:0]  corner [8];
        logic [7:0]  av, bv;
        logic [15:0] exp;
        corner = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h55, 8'hAA, 8'h7F};
        rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 0;
        @(negedge clk);

        op(8'd7, 8'd3, 16'h0015, "t1_7x3");
        op(8'h80, 8'h80, 16'h4000, "t2_m128xm128");
        op(8'h80, 8'h7F, 16'hC080, "t2_m128x127");
        op(8'hFD, 8'h55, 16'hFF01, "t3_m3x55");
        op(8'h55, 8'hFD, 16'hFF01, "t3_55xm3");
        op(8'h00, 8'hFF, 16'h0000, "t3_0xm1");

        out_ready = 0;
        start(8'h12, 8'h34);
        wait_done(lat);
        check("t4_lat", lat, 5);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            a = 8'h01;
            b = 8'h01;
            @(negedge clk);
            check("t4_hold_prod", product, 16'h03A8);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_in_ready", in_ready, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        check("t4_release_valid", out_valid, 0);
        check("t4_release_in_ready", in_ready, 1);
        op(8'h03, 8'h04, 16'h000C, "t4_next");

        start(8'd7, 8'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_product", product, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_result", out_valid, 0);
        end
        op(8'd5, 8'hFA, 16'hFFE2, "t5_5xm6");

        for (int i = 0; i < 400; i++) begin
            int p;
            av = i < 64 ? corner[i % 8] : 8'($urandom);
            bv = i < 64 ? corner[i / 8] : 8'($urandom);
            p = $signed(av) * $signed(bv);
            exp = p[15:0];
            out_ready = 0;
            start(av, bv);
            wait_done(lat);
            check("rnd_lat", lat, 5);
            check("rnd_product", product, exp);
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                @(negedge clk);
                check("rnd_stall_valid", out_valid, 1);
            end
            out_ready = 1;
            @(negedge clk);
            out_ready = 1'($urandom);
            check("rnd_single", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
